// File: rtl/trace_pkg.sv
// Shared constants and state encoding for the trace aggregator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package trace_pkg;

    localparam logic [31:0] NOP_PUTC = 32'h15000004;
    localparam logic [31:0] NOP_EXIT = 32'h15000001;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/trace_char_fifo.sv
// Per-core 8-bit character FIFO, DEPTH entries (power of two), head visible combinationally.
// Latency: a push is visible on pop_dat/empty the cycle after it is written.
// Backpressure: push is dropped when full, unless a pop happens in the same cycle.
module trace_char_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_sys,
    input  logic       push,
    input  logic [7:0] push_dat,
    input  logic       pop,
    output logic [7:0] pop_dat,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        push_ok;
    logic        pop_ok;

    // Extra pointer MSB separates the full case from the empty case.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst_sys) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/trace_aggregator.sv
// Collects putc/exit trace events from NUM_CORES cores, round-robin merges them into one character stream.
// Latency: putc in cycle N -> out_valid in cycle N+2 (empty FIFOs, idle output); optional watchdog via TRACE_AGGREGATOR_TIMEOUT_EN.
// Backpressure: output held stable while out_ready=0; per-core FIFOs absorb bursts, overflow drops and flags.
module trace_aggregator
    import trace_pkg::*;
#(
    parameter int          NUM_CORES      = 16,
    parameter int          FIFO_DEPTH     = 8,
    parameter int          TERM_CROSS_NUM = NUM_CORES,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000,
    localparam int         CW             = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
    localparam int         PW             = $clog2(NUM_CORES + 1)
) (
    input  logic                   clk,
    input  logic                   rst_sys,
    input  logic [NUM_CORES-1:0]   enable,
    input  logic [32*NUM_CORES-1:0] wb_insn,
    input  logic [32*NUM_CORES-1:0] r3,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CW-1:0]          out_core,
    output logic [7:0]             out_char,
    output logic [NUM_CORES-1:0]   termination,
    output logic [NUM_CORES-1:0]   overflow,
    output logic                   all_done,
    output logic                   timeout
);

    state_t               state;
    logic [NUM_CORES-1:0] putc_req;
    logic [NUM_CORES-1:0] exit_req;
    logic [NUM_CORES-1:0] pop;
    logic [NUM_CORES-1:0] ovf_set;
    logic [NUM_CORES-1:0] fifo_full;
    logic [NUM_CORES-1:0] fifo_empty;
    logic [7:0]           fifo_dout [NUM_CORES];
    logic [CW-1:0]        rr_ptr;
    logic [CW-1:0]        gnt_idx;
    logic [CW:0]          arb_j;
    logic                 gnt_vld;
    logic                 load_en;
    logic                 drain_ok;
    logic                 wdog_fire;
    logic [PW-1:0]        term_cnt;
    logic                 unused_r3;

    assign unused_r3 = ^r3;
    assign load_en   = !out_valid || out_ready;
    // Nothing queued, register empty next cycle, and no new character arriving.
    assign drain_ok  = (&fifo_empty) && (!out_valid || out_ready) && !(|putc_req);

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
        assign putc_req[g] = enable[g] && (wb_insn[32*g +: 32] == NOP_PUTC);
        assign exit_req[g] = enable[g] && (wb_insn[32*g +: 32] == NOP_EXIT);
        assign pop[g]      = load_en && gnt_vld && (gnt_idx == CW'(g));
        assign ovf_set[g]  = putc_req[g] && fifo_full[g] && !pop[g];

        trace_char_fifo #(
            .DEPTH(FIFO_DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst_sys  (rst_sys),
            .push     (putc_req[g]),
            .push_dat (r3[32*g +: 8]),
            .pop      (pop[g]),
            .pop_dat  (fifo_dout[g]),
            .full     (fifo_full[g]),
            .empty    (fifo_empty[g])
        );
    end

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        arb_j   = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            arb_j = {1'b0, rr_ptr} + (CW+1)'(k);
            if (arb_j >= (CW+1)'(NUM_CORES)) arb_j = arb_j - (CW+1)'(NUM_CORES);
            if (!fifo_empty[arb_j[CW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = arb_j[CW-1:0];
            end
        end
    end

    always_comb begin
        term_cnt = '0;
        for (int i = 0; i < NUM_CORES; i++) term_cnt = term_cnt + PW'(termination[i]);
    end

    always_ff @(posedge clk) begin
        if (rst_sys) begin
            state       <= RUN;
            rr_ptr      <= '0;
            out_valid   <= 1'b0;
            out_core    <= '0;
            out_char    <= '0;
            termination <= '0;
            overflow    <= '0;
            all_done    <= 1'b0;
        end else begin
            termination <= termination | exit_req;
            overflow    <= overflow | ovf_set;
            if (load_en) begin
                out_valid <= gnt_vld;
                if (gnt_vld) begin
                    out_core <= gnt_idx;
                    out_char <= fifo_dout[gnt_idx];
                    rr_ptr   <= (gnt_idx == CW'(NUM_CORES - 1)) ? '0 : gnt_idx + 1'b1;
                end
            end
            case (state)
                RUN: begin
                    if (term_cnt >= PW'(TERM_CROSS_NUM) || wdog_fire) state <= DRAIN;
                end
                DRAIN: begin
                    if (drain_ok) begin
                        state    <= DONE;
                        all_done <= 1'b1;
                    end
                end
                default: state <= DONE;
            endcase
        end
    end

`ifdef TRACE_AGGREGATOR_TIMEOUT_EN
    logic [31:0] wdog;

    assign wdog_fire = (state == RUN) && (enable == '0) && (wdog == TIMEOUT_CYCLES - 32'd1);

    always_ff @(posedge clk) begin
        if (rst_sys) begin
            wdog    <= '0;
            timeout <= 1'b0;
        end else if (state == RUN) begin
            if (enable != '0)   wdog    <= '0;
            else if (wdog_fire) timeout <= 1'b1;
            else                wdog    <= wdog + 32'd1;
        end
    end
`else
    logic [31:0] unused_timeout_cfg;

    assign unused_timeout_cfg = TIMEOUT_CYCLES;
    assign wdog_fire          = 1'b0;
    assign timeout            = 1'b0;
`endif

endmodule

// File: tb/tb_trace_aggregator.sv
// Directed bench for trace_aggregator with a scoreboard of expected (core, char) pairs.
module tb_trace_aggregator;
    import trace_pkg::*;

    localparam int N = 16;

    logic            clk = 1'b0;
    logic            rst_sys = 1'b1;
    logic [N-1:0]    enable = '0;
    logic [32*N-1:0] wb_insn = '0;
    logic [32*N-1:0] r3 = '0;
    logic            out_ready = 1'b0;
    logic            out_valid;
    logic [3:0]      out_core;
    logic [7:0]      out_char;
    logic [N-1:0]    termination;
    logic [N-1:0]    overflow;
    logic            all_done;
    logic            timeout;

    int          tests = 0;
    int          fails = 0;
    int          hs;
    logic [15:0] sb [$];
    logic [15:0] mon_exp;

    always #5 clk = ~clk;

    trace_aggregator #(
        .NUM_CORES      (N),
        .FIFO_DEPTH     (8),
        .TERM_CROSS_NUM (16),
        .TIMEOUT_CYCLES (32'd100)
    ) dut (
        .clk         (clk),
        .rst_sys     (rst_sys),
        .enable      (enable),
        .wb_insn     (wb_insn),
        .r3          (r3),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_core    (out_core),
        .out_char    (out_char),
        .termination (termination),
        .overflow    (overflow),
        .all_done    (all_done),
        .timeout     (timeout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 0);
        check({tag, "_core"}, 32'(out_core), 0);
        check({tag, "_char"}, 32'(out_char), 0);
        check({tag, "_term"}, 32'(termination), 0);
        check({tag, "_ovf"}, 32'(overflow), 0);
        check({tag, "_done"}, 32'(all_done), 0);
        check({tag, "_timeout"}, 32'(timeout), 0);
    endtask

    task automatic set_putc(input int c, input logic [7:0] ch);
        enable[c]          = 1'b1;
        wb_insn[32*c +: 32] = NOP_PUTC;
        r3[32*c +: 32]      = {24'h0, ch};
    endtask

    task automatic set_exit(input int c);
        enable[c]           = 1'b1;
        wb_insn[32*c +: 32] = NOP_EXIT;
    endtask

    task automatic clear_in();
        enable  = '0;
        wb_insn = '0;
        r3      = '0;
    endtask

    task automatic expect_char(input int c, input logic [7:0] ch);
        sb.push_back({8'(c), ch});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_sys = 1'b1;
        clear_in();
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_sys = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst_sys && out_valid && out_ready) begin
            tests++;
            assert (sb.size() > 0) else begin
                fails++;
                $error("FAIL sb_extra: observed core %0d char 0x%0h, expected no output", out_core, out_char);
            end
            if (sb.size() > 0) begin
                mon_exp = sb.pop_front();
                check("out_core", 32'(out_core), 32'(mon_exp[15:8]));
                check("out_char", 32'(out_char), 32'(mon_exp[7:0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed simulation still running, expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        // Reset state
        do_reset();
        @(negedge clk);
        check_zero("rst");

        // Single putc latency: visible two cycles later for exactly one cycle
        out_ready = 1'b1;
        tick();
        set_putc(3, 8'h41);
        expect_char(3, 8'h41);
        tick();
        clear_in();
        @(negedge clk);
        check("lat_n1_valid", 32'(out_valid), 0);
        @(negedge clk);
        check("lat_n2_valid", 32'(out_valid), 1);
        @(negedge clk);
        check("lat_n3_valid", 32'(out_valid), 0);
        check("lat_sb_empty", sb.size(), 0);

        // Round robin: 0,1,2 then 0,2 (pointer at 3 wraps) then 0,1 then 2,0 (pointer at 2)
        do_reset();
        out_ready = 1'b1;
        set_putc(0, 8'h61); set_putc(1, 8'h62); set_putc(2, 8'h63);
        expect_char(0, 8'h61); expect_char(1, 8'h62); expect_char(2, 8'h63);
        tick();
        clear_in();
        repeat (6) tick();
        set_putc(0, 8'h64); set_putc(2, 8'h65);
        expect_char(0, 8'h64); expect_char(2, 8'h65);
        tick();
        clear_in();
        repeat (5) tick();
        set_putc(0, 8'h66); set_putc(1, 8'h67);
        expect_char(0, 8'h66); expect_char(1, 8'h67);
        tick();
        clear_in();
        repeat (5) tick();
        set_putc(0, 8'h68); set_putc(2, 8'h69);
        expect_char(2, 8'h69); expect_char(0, 8'h68);
        tick();
        clear_in();
        repeat (5) tick();
        check("rr_sb_empty", sb.size(), 0);

        // Overflow: 10 putcs with out_ready=0 fill register + 8 FIFO slots, 10th dropped
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            set_putc(5, 8'h30 + 8'(i));
            if (i < 9) expect_char(5, 8'h30 + 8'(i));
            @(negedge clk);
            if (i == 9) check("ovf_before_drop", 32'(overflow), 0);
            tick();
        end
        clear_in();
        @(negedge clk);
        check("ovf_after_drop", 32'(overflow), 32'h0020);
        tick();
        // Push into the full FIFO in the same cycle it is popped: accepted
        out_ready = 1'b1;
        set_putc(5, 8'h5A);
        expect_char(5, 8'h5A);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("b2b_valid", 32'(out_valid), 1);
            tick();
            if (k == 0) clear_in();
        end
        @(negedge clk);
        check("b2b_drained", 32'(out_valid), 0);
        check("ovf_sb_empty", sb.size(), 0);

        // Completion waits for pending characters
        do_reset();
        out_ready = 1'b0;
        set_putc(7, 8'h78); set_putc(9, 8'h79);
        expect_char(7, 8'h78); expect_char(9, 8'h79);
        tick();
        clear_in();
        tick();
        for (int c = 0; c < N; c++) set_exit(c);
        tick();
        clear_in();
        repeat (4) @(negedge clk);
        check("drain_term", 32'(termination), 32'hFFFF);
        check("drain_stall_done", 32'(all_done), 0);
        tick();
        out_ready = 1'b1;
        hs = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) hs++;
            if (hs == 2) break;
        end
        check("drain_handshakes", hs, 2);
        check("done_not_early", 32'(all_done), 0);
        @(negedge clk);
        check("done_after_last", 32'(all_done), 1);
        repeat (3) @(negedge clk);
        check("done_sticky", 32'(all_done), 1);
        check("done_timeout", 32'(timeout), 0);

        // Reset during DRAIN with characters pending
        do_reset();
        out_ready = 1'b0;
        set_putc(1, 8'h11); set_putc(2, 8'h22);
        tick();
        clear_in();
        for (int c = 0; c < N; c++) set_exit(c);
        tick();
        clear_in();
        repeat (3) tick();
        rst_sys = 1'b1;
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        check_zero("midrst");
        @(posedge clk);
        #1 rst_sys = 1'b0;
        out_ready = 1'b1;
        set_putc(4, 8'h71);
        expect_char(4, 8'h71);
        tick();
        clear_in();
        repeat (6) @(negedge clk);
        check("midrst_sb_empty", sb.size(), 0);
        check("midrst_done", 32'(all_done), 0);

        // Idle watchdog
        do_reset();
`ifdef TRACE_AGGREGATOR_TIMEOUT_EN
        for (int i = 1; i <= 100; i++) @(negedge clk);
        check("wd_before", 32'(timeout), 0);
        @(negedge clk);
        check("wd_fire", 32'(timeout), 1);
        @(negedge clk);
        check("wd_done", 32'(all_done), 1);
`else
        repeat (110) @(negedge clk);
        check("wd_absent_timeout", 32'(timeout), 0);
        check("wd_absent_done", 32'(all_done), 0);
`endif
        check("final_sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
